// File: rtl/hash_table.sv
// Shared types and widths for the hash-table lookup pipeline.
package hash_table;

  localparam int unsigned BUCKET_WIDTH   = 8;
  localparam int unsigned HEAD_PTR_WIDTH = 8;
  localparam int unsigned KEY_WIDTH      = 16;
  localparam int unsigned VALUE_WIDTH    = 16;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_op_t;

  typedef struct packed {
    ht_op_t                  cmd;
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    logic [BUCKET_WIDTH-1:0] bucket;
  } ht_command_t;

  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_ram_data_t;

  typedef struct packed {
    ht_op_t                    cmd;
    logic [KEY_WIDTH-1:0]      key;
    logic [VALUE_WIDTH-1:0]    value;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_ptr_val;
  } ht_pdata_t;

endpackage

// File: rtl/ht_pdata_fifo.sv
// Output buffer for enriched tasks; output comes straight from storage registers.
// Pointers carry an extra wrap bit to tell full from empty.
module ht_pdata_fifo
  import hash_table::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      wr_en_i,
  input  ht_pdata_t wr_data_i,
  input  logic      rd_en_i,
  output ht_pdata_t rd_data_o,
  output logic      rd_valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full_c;
  logic          empty_c;
  ht_pdata_t     mem_q [DEPTH];

  assign full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c    = (wr_ptr_q == rd_ptr_q);
  assign rd_valid_o = !empty_c;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + PW'(rd_en_i && !empty_c);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Credit flow control upstream makes overflow impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                  !(wr_en_i && full_c))
    else $error("ht_pdata_fifo write while full");

endmodule

// File: rtl/head_table_lookup.sv
// Head-pointer lookup stage: issues a head-RAM read per accepted task, carries the
// task alongside the read, and buffers the enriched result under credit flow control.
module head_table_lookup
  import hash_table::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned A_WIDTH     = BUCKET_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  ht_command_t        task_i,
  input  logic               task_valid_i,
  output logic               task_ready_o,
  output logic [A_WIDTH-1:0] rd_addr_o,
  output logic               rd_en_o,
  input  head_ram_data_t     rd_data_i,
  output ht_pdata_t          pdata_o,
  output logic               pdata_valid_o,
  input  logic               pdata_ready_i,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                   run_q;
  logic [CW-1:0]          credits_q, credits_d;
  logic [RAM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  ht_command_t            pipe_cmd_q [RAM_LATENCY];
  logic                   accept_c;
  logic                   pop_c;
  logic                   fifo_wr_c;
  ht_pdata_t              fifo_wdata_c;

  // run_q holds intake off until the first edge after reset release.
  assign task_ready_o = run_q && (credits_q != '0);
  assign accept_c     = task_valid_i && task_ready_o;
  assign pop_c        = pdata_valid_o && pdata_ready_i;
  assign rd_en_o      = accept_c;
  assign rd_addr_o    = accept_c ? A_WIDTH'(task_i.bucket) : '0;
  assign busy_o       = (credits_q != CW'(FIFO_DEPTH));

  always_comb begin
    credits_d = credits_q;
    case ({accept_c, pop_c})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
    pipe_vld_d    = '0;
    pipe_vld_d[0] = accept_c;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q      <= 1'b0;
      credits_q  <= CW'(FIFO_DEPTH);
      pipe_vld_q <= '0;
    end else begin
      run_q      <= 1'b1;
      credits_q  <= credits_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  // Task fields ride beside the read; only the valid bits need reset.
  always_ff @(posedge clk_i) begin
    pipe_cmd_q[0] <= task_i;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) pipe_cmd_q[i] <= pipe_cmd_q[i-1];
  end

  always_comb begin
    fifo_wr_c                 = pipe_vld_q[RAM_LATENCY-1];
    fifo_wdata_c              = '0;
    fifo_wdata_c.cmd          = pipe_cmd_q[RAM_LATENCY-1].cmd;
    fifo_wdata_c.key          = pipe_cmd_q[RAM_LATENCY-1].key;
    fifo_wdata_c.value        = pipe_cmd_q[RAM_LATENCY-1].value;
    fifo_wdata_c.bucket       = pipe_cmd_q[RAM_LATENCY-1].bucket;
    fifo_wdata_c.head_ptr     = rd_data_i.ptr;
    fifo_wdata_c.head_ptr_val = rd_data_i.ptr_val;
  end

  ht_pdata_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (fifo_wr_c),
    .wr_data_i  (fifo_wdata_c),
    .rd_en_i    (pop_c),
    .rd_data_o  (pdata_o),
    .rd_valid_o (pdata_valid_o)
  );

endmodule
